fb_scan_reader: RTL and testbench

- Downstream consumer of the 24-bit simple dual-port frame/texture BRAM: drives its read port (ce, addr) and turns the registered read data into a valid/ready pixel stream with start-of-frame and end-of-line flags.
- Sits between the BRAM read side and the video/pixel output path.
- Single clock domain.
- Absorbs the RAM's 1-cycle read latency with a 2-entry prefetch buffer, so it sustains 1 pixel/cycle under no backpressure.

---
 rtl/fb_scan_reader.sv | 180 ++++++++++++++++++
 tb/tb_fb_scan_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scan_reader.sv
// Frame scan reader: walks a registered-read BRAM and presents the words as a
// valid/ready pixel stream with sof/eol flags, hiding read latency with a 2-entry FIFO.
module fb_scan_reader #(
  parameter int DP    = 512,
  parameter int AW    = $clog2(DP) - 1,
  parameter int DW    = 24,
  parameter int H_ACT = 32,
  parameter int V_ACT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   base_addr,
  output logic          ram_ce,
  output logic [AW:0]   ram_addr,
  input  logic [DW-1:0] ram_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_sof,
  output logic          m_eol,
  output logic          busy,
  output logic          done
);

  localparam int NPIX = H_ACT * V_ACT;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int XW   = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW   = (V_ACT > 1) ? $clog2(V_ACT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_r;
  logic [AW:0]   base_r;
  logic [CW-1:0] issue_cnt_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          inflight_r;
  logic          tag_sof_r;
  logic          tag_eol_r;
  logic [DW-1:0] fifo_data_r [2];
  logic          fifo_sof_r  [2];
  logic          fifo_eol_r  [2];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    count_r;

  logic          push_s;
  logic          pop_s;
  logic [2:0]    occ_s;
  logic [AW+1:0] addr_sum_s;
  logic [AW+1:0] addr_wrap_s;

  // Read-issue throttle, wrapped read address and FIFO head decode
  always_comb begin
    push_s      = inflight_r;
    m_valid     = (count_r != 2'd0);
    pop_s       = m_valid & m_ready;
    m_data      = fifo_data_r[rd_ptr_r];
    m_sof       = m_valid & fifo_sof_r[rd_ptr_r];
    m_eol       = m_valid & fifo_eol_r[rd_ptr_r];
    // occupancy counts both buffered words and the read still in the RAM pipe
    occ_s       = {1'b0, count_r} + {2'b00, inflight_r};
    addr_sum_s  = (AW+2)'(base_r) + (AW+2)'(issue_cnt_r);
    addr_wrap_s = addr_sum_s;
    if (addr_sum_s >= (AW+2)'(DP)) begin
      addr_wrap_s = addr_sum_s - (AW+2)'(DP);
    end else begin
      addr_wrap_s = addr_sum_s;
    end
    ram_ce   = 1'b0;
    ram_addr = {(AW+1){1'b0}};
    if (state_r == RUN) begin
      ram_ce   = (occ_s < (3'd2 + {2'b00, pop_s}));
      ram_addr = addr_wrap_s[AW:0];
    end else begin
      ram_ce   = 1'b0;
      ram_addr = {(AW+1){1'b0}};
    end
  end

  // Frame sequencing, request counters and the tag stage aligned with ram_dout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      base_r      <= {(AW+1){1'b0}};
      issue_cnt_r <= {CW{1'b0}};
      x_r         <= {XW{1'b0}};
      y_r         <= {YW{1'b0}};
      inflight_r  <= 1'b0;
      tag_sof_r   <= 1'b0;
      tag_eol_r   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done       <= 1'b0;
      inflight_r <= ram_ce;
      case (state_r)
        IDLE: begin
          // a start coinciding with the done pulse still belongs to the old frame
          if (start && !done) begin
            state_r     <= RUN;
            base_r      <= base_addr;
            issue_cnt_r <= {CW{1'b0}};
            x_r         <= {XW{1'b0}};
            y_r         <= {YW{1'b0}};
            busy        <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (ram_ce && (issue_cnt_r == CW'(NPIX - 1))) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          if (pop_s && (count_r == 2'd1) && !inflight_r) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
      if (ram_ce) begin
        issue_cnt_r <= issue_cnt_r + CW'(1);
        tag_sof_r   <= (issue_cnt_r == {CW{1'b0}});
        tag_eol_r   <= (x_r == XW'(H_ACT - 1));
        if (x_r == XW'(H_ACT - 1)) begin
          x_r <= {XW{1'b0}};
          y_r <= (y_r == YW'(V_ACT - 1)) ? {YW{1'b0}} : (y_r + YW'(1));
        end else begin
          x_r <= x_r + XW'(1);
        end
      end
    end
  end

  // Prefetch FIFO: capture returning read data with its tags, release on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_r[i] <= {DW{1'b0}};
        fifo_sof_r[i]  <= 1'b0;
        fifo_eol_r[i]  <= 1'b0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= ram_dout;
        fifo_sof_r[wr_ptr_r]  <= tag_sof_r;
        fifo_eol_r[wr_ptr_r]  <= tag_eol_r;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench for fb_scan_reader: behavioural BRAM, frame receiver task with
// per-beat data/flag/address checks, and scenario tasks run in sequence.
module tb_fb_scan_reader;

  localparam int DP    = 512;
  localparam int AW    = 8;
  localparam int DW    = 24;
  localparam int H_ACT = 32;
  localparam int V_ACT = 16;
  localparam int NPIX  = H_ACT * V_ACT;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   base_addr;
  logic          ram_ce;
  logic [AW:0]   ram_addr;
  logic [DW-1:0] ram_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eol;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DP];
  int            checks = 0;
  int            passes = 0;

  fb_scan_reader #(.DP(DP), .DW(DW), .H_ACT(H_ACT), .V_ACT(V_ACT)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .ram_ce(ram_ce), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // registered-read RAM, one cycle of latency
  always @(posedge clk) begin
    if (ram_ce) ram_dout <= mem[ram_addr];
  end

  function automatic logic [DW-1:0] word_of(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b + 8'd2, b + 8'd1, b};
  endfunction

  // mode 0: always ready, 1: random 50%, 2: ready low for 'stall' cycles from start
  task automatic recv_frame(input int base, input int mode, input int stall,
                            input int restart_beat, input string tag);
    int cyc, beats, issued, dones, first_v, stall_ce, exp_addr;
    logic rs, rs_done, prev_stall, pop, ps, pe;
    logic [DW-1:0] pd, exp_d;
    logic [AW:0] b9;
    b9 = base[AW:0];
    cyc = 0; beats = 0; issued = 0; dones = 0; first_v = -1; stall_ce = 0;
    rs_done = 1'b0; prev_stall = 1'b0; pd = '0; ps = 1'b0; pe = 1'b0;
    while (dones == 0 && cyc < 3000) begin
      @(negedge clk);
      rs = (restart_beat >= 0) && (beats == restart_beat) && !rs_done;
      if (rs) rs_done = 1'b1;
      start = (cyc == 0) || rs;
      base_addr = rs ? (b9 + 9'd7) : b9;
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = ($urandom_range(0, 1) == 1);
        default: m_ready = (cyc >= stall);
      endcase
      #1;
      pop = m_valid && m_ready;
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) $display("FAIL %s busy_rise: got %b want 1", tag, busy);
        else passes++;
      end
      if (done) begin
        dones++;
        checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", tag, busy);
        else passes++;
      end
      if (ram_ce) begin
        exp_addr = (base + issued) % DP;
        checks++;
        if (ram_addr !== exp_addr[AW:0])
          $display("FAIL %s ram_addr read %0d: got %0d want %0d", tag, issued, ram_addr, exp_addr);
        else passes++;
        checks++;
        if (issued - beats - int'(pop) >= 2)
          $display("FAIL %s ce_overissue read %0d: got occupancy %0d want <2", tag, issued, issued - beats - int'(pop));
        else passes++;
        issued++;
        if (cyc < stall) stall_ce++;
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== pd || m_sof !== ps || m_eol !== pe)
          $display("FAIL %s stall_hold beat %0d: got v%b %h s%b e%b want v1 %h s%b e%b",
                   tag, beats, m_valid, m_data, m_sof, m_eol, pd, ps, pe);
        else passes++;
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (mode != 1 && m_ready && beats > 0 && beats < NPIX) begin
        checks++;
        if (m_valid !== 1'b1) $display("FAIL %s bubble beat %0d: got m_valid %b want 1", tag, beats, m_valid);
        else passes++;
      end
      if (pop) begin
        exp_d = word_of((base + beats) % DP);
        checks++;
        if (m_data !== exp_d || m_sof !== (beats == 0) || m_eol !== ((beats % H_ACT) == H_ACT - 1))
          $display("FAIL %s beat %0d: got %h s%b e%b want %h s%b e%b", tag, beats, m_data, m_sof, m_eol,
                   exp_d, (beats == 0), ((beats % H_ACT) == H_ACT - 1));
        else passes++;
        beats++;
      end
      prev_stall = m_valid && !m_ready;
      pd = m_data; ps = m_sof; pe = m_eol;
      cyc++;
    end
    start = 1'b0;
    base_addr = b9;
    checks++;
    if (first_v != 3) $display("FAIL %s first_valid_cycle: got %0d want 3", tag, first_v);
    else passes++;
    checks++;
    if (beats != NPIX) $display("FAIL %s beat_count: got %0d want %0d", tag, beats, NPIX);
    else passes++;
    checks++;
    if (issued != NPIX) $display("FAIL %s read_count: got %0d want %0d", tag, issued, NPIX);
    else passes++;
    checks++;
    if (dones != 1) $display("FAIL %s done_count: got %0d want 1", tag, dones);
    else passes++;
    if (stall > 0) begin
      checks++;
      if (stall_ce != 2) $display("FAIL %s stall_ce_count: got %0d want 2", tag, stall_ce);
      else passes++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({ram_ce, ram_addr, m_valid, m_data, m_sof, m_eol, busy, done} !== '0)
      $display("FAIL reset_outputs: got ce%b a%0d v%b d%h s%b e%b busy%b done%b want all 0",
               ram_ce, ram_addr, m_valid, m_data, m_sof, m_eol, busy, done);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    recv_frame(0, 0, 0, -1, "basic");
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_after_done: got done%b busy%b want 0 0", done, busy);
    else passes++;
  endtask

  task automatic test_random_ready();
    recv_frame(0, 1, 0, -1, "random_ready");
  endtask

  task automatic test_wrap();
    recv_frame(500, 0, 0, -1, "wrap500");
  endtask

  task automatic test_back_to_back();
    recv_frame(0, 0, 0, 100, "restart_ignored");
    recv_frame(37, 0, 0, -1, "start_after_done");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL start_in_done_cycle: got busy %b want 0", busy);
    else passes++;
    @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || ram_ce !== 1'b0)
      $display("FAIL start_in_done_cycle_idle: got v%b ce%b want 0 0", m_valid, ram_ce);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int beats, cyc, dones;
    beats = 0; cyc = 0; dones = 0;
    base_addr = '0; m_ready = 1'b1;
    while (beats < 200 && cyc < 1000) begin
      @(negedge clk);
      start = (cyc == 0);
      #1;
      if (m_valid && m_ready) beats++;
      cyc++;
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({ram_ce, ram_addr, m_valid, m_data, m_sof, m_eol, busy, done} !== '0)
      $display("FAIL mid_reset_outputs: got ce%b a%0d v%b d%h s%b e%b busy%b done%b want all 0",
               ram_ce, ram_addr, m_valid, m_data, m_sof, m_eol, busy, done);
    else passes++;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (done) dones++;
    end
    checks++;
    if (dones != 0) $display("FAIL mid_reset_no_done: got %0d done pulses want 0", dones);
    else passes++;
    recv_frame(0, 0, 0, -1, "after_reset");
  endtask

  task automatic test_stall_start();
    recv_frame(0, 2, 10, -1, "stall10");
  endtask

  initial begin
    for (int k = 0; k < DP; k++) mem[k] = word_of(k);
    test_reset();
    test_basic();
    test_random_ready();
    test_wrap();
    test_back_to_back();
    test_reset_mid_frame();
    test_stall_start();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
